// File: rtl/phy_tx_stripe_ser.sv
// N-lane round-robin striping serializer: words are grouped NUM_LANES at a time and shifted out MSB-first,
// with all lanes aligned on DATA_W-cycle word periods. Macro STRIPE_PARTIAL_FLUSH_EN enables partial-group flush.
module phy_tx_stripe_ser #(
    parameter int               NUM_LANES = 2,
    parameter int               DATA_W    = 32,
    parameter int               SYM_W     = 8,
    parameter logic [SYM_W-1:0] IDLE_SYM  = 8'hBC
) (
    input  logic                 clk_32f,
    input  logic                 reset_L,
    input  logic [NUM_LANES-1:0] active_lane,
    input  logic                 valid_in,
    input  logic [DATA_W-1:0]    data_in,
    output logic                 ready_out,
    output logic [NUM_LANES-1:0] data_out_lane,
    output logic [NUM_LANES-1:0] valid_out_lane,
    output logic                 word_start
);
    localparam int              CW        = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int              PW        = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam logic [CW-1:0]   LAST_BIT  = CW'(DATA_W - 1);
    localparam logic [PW-1:0]   LAST_LANE = PW'(NUM_LANES - 1);
    localparam logic [DATA_W-1:0] IDLE_WORD = {(DATA_W / SYM_W){IDLE_SYM}};

    logic [CW-1:0]        bit_cnt;
    logic [PW-1:0]        ptr;
    logic [PW-1:0]        ptr_nxt;
    logic [NUM_LANES-1:0] full;
    logic [NUM_LANES-1:0] full_nxt;
    logic [NUM_LANES-1:0] load_mask;
    logic [DATA_W-1:0]    holding [NUM_LANES];
    logic [DATA_W-1:0]    shift_q [NUM_LANES];
    logic                 active;
    logic                 boundary;
    logic                 group_load;
    logic                 accept;

    assign active     = &active_lane;
    assign boundary   = (bit_cnt == LAST_BIT);
    assign group_load = boundary & active & (&full);
    // A full group leaving at this edge frees holding[0] for a same-cycle write: zero-bubble streaming.
    assign ready_out  = active & (~full[ptr] | group_load);
    assign accept     = valid_in & ready_out;

`ifdef STRIPE_PARTIAL_FLUSH_EN
    logic flush;
    assign flush = boundary & active & (ptr != '0) & ~(&full) & ~valid_in;
`endif

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        load_mask = '0;
        full_nxt  = full;
        ptr_nxt   = ptr;
        if (group_load) begin
            load_mask = '1;
            full_nxt  = '0;
        end
`ifdef STRIPE_PARTIAL_FLUSH_EN
        else if (flush) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (PW'(i) < ptr) begin
                    load_mask[i] = 1'b1;
                    full_nxt[i]  = 1'b0;
                end
            end
            ptr_nxt = '0;
        end
`endif
        if (accept) begin
            full_nxt[ptr] = 1'b1;
            ptr_nxt       = (ptr == LAST_LANE) ? '0 : ptr + PW'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            bit_cnt        <= '0;
            ptr            <= '0;
            full           <= '0;
            valid_out_lane <= '0;
            word_start     <= 1'b0;
            for (int i = 0; i < NUM_LANES; i++) begin
                shift_q[i] <= '0;
            end
        end else begin
            bit_cnt    <= boundary ? '0 : bit_cnt + CW'(1);
            word_start <= boundary;
            ptr        <= ptr_nxt;
            full       <= full_nxt;
            if (boundary) begin
                valid_out_lane <= load_mask;
            end
            for (int i = 0; i < NUM_LANES; i++) begin
                if (boundary) begin
                    shift_q[i] <= load_mask[i] ? holding[i] : IDLE_WORD;
                end else begin
                    shift_q[i] <= {shift_q[i][DATA_W-2:0], 1'b0};
                end
            end
        end
    end

    // NOTE: holding data is not reset; the full flags alone say whether an entry is meaningful.
    always_ff @(posedge clk_32f) begin
        if (accept) begin
            holding[ptr] <= data_in;
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane_out
        assign data_out_lane[g] = shift_q[g][DATA_W-1];
    end

endmodule

// File: tb/tb_phy_tx_stripe_ser.sv
// Scoreboard bench for phy_tx_stripe_ser (2 lanes x 32 bits): stimulus queues the expected word period,
// a negedge monitor deserializes each lane and compares whole periods in order.
module tb_phy_tx_stripe_ser;
    localparam int NL = 2;
    localparam int DW = 32;
    localparam logic [DW-1:0] IDLE = 32'hBCBC_BCBC;

    typedef struct {
        logic [DW-1:0] w0;
        logic [DW-1:0] w1;
        logic [NL-1:0] v;
    } exp_t;

    logic          clk_32f = 1'b0;
    logic          reset_L;
    logic [NL-1:0] active_lane;
    logic          valid_in;
    logic [DW-1:0] data_in;
    logic          ready_out;
    logic [NL-1:0] data_out_lane;
    logic [NL-1:0] valid_out_lane;
    logic          word_start;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    phy_tx_stripe_ser #(.NUM_LANES(NL), .DATA_W(DW), .SYM_W(8), .IDLE_SYM(8'hBC)) dut (
        .clk_32f        (clk_32f),
        .reset_L        (reset_L),
        .active_lane    (active_lane),
        .valid_in       (valid_in),
        .data_in        (data_in),
        .ready_out      (ready_out),
        .data_out_lane  (data_out_lane),
        .valid_out_lane (valid_out_lane),
        .word_start     (word_start)
    );

    always #5 clk_32f = ~clk_32f;

    task automatic check(input logic [63:0] act, input logic [63:0] expv, input string name);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic push(input logic [DW-1:0] w0, input logic [DW-1:0] w1, input logic [NL-1:0] v);
        exp_t e;
        e.w0 = w0;
        e.w1 = w1;
        e.v  = v;
        exp_q.push_back(e);
    endtask

    // Returns at posedge+1 of the first cycle with word_start high.
    task automatic wait_ws(output int n);
        n = 0;
        do begin
            @(posedge clk_32f);
            #1;
            n++;
        end while (!word_start && n < 100);
        if (!word_start) check(64'(word_start), 64'd1, "word_start_timeout");
    endtask

    // Holds valid_in with w until accepted; leaves valid_in high at posedge+1 after acceptance.
    task automatic send(input logic [DW-1:0] w, output int stalls);
        stalls   = 0;
        valid_in = 1'b1;
        data_in  = w;
        while (!ready_out && stalls < 200) begin
            @(posedge clk_32f);
            #1;
            stalls++;
        end
        if (!ready_out) check(64'(ready_out), 64'd1, "accept_timeout");
        @(posedge clk_32f);
        #1;
    endtask

    // Monitor: deserialize one word period per lane, then compare against the oldest expectation.
    int            mon_cnt = 0;
    logic [DW-1:0] cap0, cap1;
    logic [NL-1:0] vcap;
    always @(negedge clk_32f) begin
        exp_t e;
        if (!reset_L) begin
            mon_cnt = 0;
        end else begin
            if (word_start) begin
                check(64'(mon_cnt), 64'd0, "word_start_align");
                mon_cnt = 0;
                vcap    = valid_out_lane;
            end
            if (word_start || mon_cnt != 0) begin
                cap0 = {cap0[DW-2:0], data_out_lane[0]};
                cap1 = {cap1[DW-2:0], data_out_lane[1]};
                if (valid_out_lane !== vcap) check(64'(valid_out_lane), 64'(vcap), "valid_stable");
                mon_cnt++;
                if (mon_cnt == DW) begin
                    mon_cnt = 0;
                    if (exp_q.size() == 0) begin
                        check(64'(cap0), 64'hFFFF_FFFF_FFFF_FFFF, "unexpected_word");
                    end else begin
                        e = exp_q.pop_front();
                        check(64'(cap0), 64'(e.w0), "lane0_word");
                        check(64'(cap1), 64'(e.w1), "lane1_word");
                        check(64'(vcap), 64'(e.v), "valid_out_lane");
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int st;
        int stall_sum;
        logic [DW-1:0] stream [8];
        stream = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444,
                   32'h5555_5555, 32'h6666_6666, 32'h7777_7777, 32'h8888_8888};

        reset_L     = 1'b0;
        active_lane = '1;
        valid_in    = 1'b0;
        data_in     = '0;
        repeat (3) @(posedge clk_32f);
        #1;
        check(64'(data_out_lane), 64'd0, "reset_data");
        check(64'(valid_out_lane), 64'd0, "reset_valid");
        check(64'(word_start), 64'd0, "reset_word_start");
        reset_L = 1'b1;
        push(IDLE, IDLE, 2'b00);                       // period 1

        repeat (10) @(posedge clk_32f);
        #1;
        check(64'(data_out_lane), 64'd0, "pre_boundary_zero");
        check(64'(ready_out), 64'd1, "ready_after_reset");
        wait_ws(n);                                    // period 1 start
        check(64'(n), 64'd22, "first_boundary");
        push(IDLE, IDLE, 2'b00);                       // period 2

        wait_ws(n);                                    // period 2: two words
        check(64'(n), 64'd32, "period_len");
        send(32'hDEAD_BEEF, st);
        send(32'h1234_5678, st);
        valid_in = 1'b0;
        push(32'hDEAD_BEEF, 32'h1234_5678, 2'b11);     // period 3

        wait_ws(n);                                    // period 3
        push(IDLE, IDLE, 2'b00);                       // period 4

        wait_ws(n);                                    // period 4: continuous stream
        push(stream[0], stream[1], 2'b11);
        push(stream[2], stream[3], 2'b11);
        push(stream[4], stream[5], 2'b11);
        push(stream[6], stream[7], 2'b11);             // periods 5..8
        stall_sum = 0;
        for (int k = 0; k < 8; k++) begin
            send(stream[k], st);
            stall_sum += st;
        end
        valid_in = 1'b0;
        check(64'(stall_sum), 64'd89, "stream_stall_cycles");

        wait_ws(n);                                    // period 8: link drop test
        send(32'hCAFE_F00D, st);
        send(32'h0BAD_C0DE, st);
        valid_in = 1'b0;
        push(32'hCAFE_F00D, 32'h0BAD_C0DE, 2'b11);     // period 9

        wait_ws(n);                                    // period 9
        repeat (9) @(posedge clk_32f);
        #1;
        check(64'(ready_out), 64'd1, "ready_before_drop");
        send(32'h8000_0001, st);
        valid_in    = 1'b0;
        active_lane = 2'b01;
        #1;
        check(64'(ready_out), 64'd0, "ready_while_inactive");
        push(IDLE, IDLE, 2'b00);                       // period 10

        wait_ws(n);                                    // period 10
        check(64'(ready_out), 64'd0, "ready_still_inactive");
        push(IDLE, IDLE, 2'b00);                       // period 11

        wait_ws(n);                                    // period 11: link back up
        active_lane = '1;
        #1;
        check(64'(ready_out), 64'd1, "ready_after_reactivate");
        send(32'h7FFF_FFFE, st);
        valid_in = 1'b0;
        push(32'h8000_0001, 32'h7FFF_FFFE, 2'b11);     // period 12

        wait_ws(n);                                    // period 12
        push(IDLE, IDLE, 2'b00);                       // period 13

        wait_ws(n);                                    // period 13
        send(32'hFFFF_FFFF, st);
        send(32'hFFFF_0000, st);
        valid_in = 1'b0;
        push(32'hFFFF_FFFF, 32'hFFFF_0000, 2'b11);     // period 14

        wait_ws(n);                                    // period 14: reset at bit 10
        repeat (10) @(posedge clk_32f);
        #1;
        check(64'(data_out_lane), 64'd3, "pre_reset_data");
        reset_L = 1'b0;
        #1;
        check(64'(data_out_lane), 64'd0, "midword_reset_data");
        check(64'(valid_out_lane), 64'd0, "midword_reset_valid");
        check(64'(word_start), 64'd0, "midword_reset_ws");
        exp_q.delete();
        repeat (2) @(posedge clk_32f);
        #1;
        reset_L = 1'b1;
        push(IDLE, IDLE, 2'b00);                       // period 1 after reset

        wait_ws(n);                                    // period 1: single word
        check(64'(n), 64'd32, "reset_to_first_idle");
        send(32'hA5A5_A5A5, st);
        valid_in = 1'b0;
`ifdef STRIPE_PARTIAL_FLUSH_EN
        push(32'hA5A5_A5A5, IDLE, 2'b01);              // period 2
`else
        push(IDLE, IDLE, 2'b00);                       // period 2
`endif
        wait_ws(n);                                    // period 2
        push(IDLE, IDLE, 2'b00);                       // period 3
        wait_ws(n);                                    // period 3
        push(IDLE, IDLE, 2'b00);                       // period 4
        wait_ws(n);                                    // period 4

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/phy_tx_stripe_ser.md
Name: phy_tx_stripe_ser

Overview:
Parametrised N-lane striping serializer for the PHY transmit path. It accepts DATA_W-bit words on a valid/ready handshake and stripes them round-robin across NUM_LANES lanes: word k goes to lane k mod NUM_LANES. Each lane serializes its word MSB-first on one bit clock, and all lanes start and end their words on the same cycle. Lanes with no data send an idle symbol pattern. The block runs from a single bit-rate clock and replaces the fixed two-lane striping, width-conversion and serializer chain.

Parameters:
NUM_LANES, 2, number of serial lanes (>=1)
DATA_W, 32, word width; equals bits per lane per word period (multiple of SYM_W)
SYM_W, 8, symbol width used to build the idle word
IDLE_SYM, 8'hBC, idle symbol, replicated DATA_W/SYM_W times to form the idle word

Ports:
clk_32f  input  1  bit clock; all logic on its rising edge
reset_L  input  1  asynchronous active-low reset
active_lane  input  NUM_LANES  per-lane link-up; link is active when all bits are 1
valid_in  input  1  input word valid
data_in  input  DATA_W  input word
ready_out  output  1  block can accept data_in this cycle
data_out_lane  output  NUM_LANES  serial bit per lane (registered)
valid_out_lane  output  NUM_LANES  1 while the lane is sending a data word, 0 for idle
word_start  output  1  registered pulse, high in the first bit cycle of every word period

Behaviour:
- Reset (async, reset_L=0): bit_cnt=0, stripe ptr=0, all holding registers empty, shift registers=0, data_out_lane=0, valid_out_lane=0, word_start=0.
- Before the first word boundary after reset, lanes output 0, not idle.
- bit_cnt counts 0..DATA_W-1 and wraps. A boundary is a cycle with bit_cnt==DATA_W-1.
- At each boundary edge every lane loads either data or the idle word. The new word's MSB appears on data_out_lane in the next cycle (bit_cnt=0), when word_start=1.
- Shifting: MSB first, one bit per clock. data_out_lane[i] is shift[i][DATA_W-1].
- Per lane: one holding register plus a full flag.
- Accept = valid_in & ready_out. On accept, data_in is written to holding[ptr] and ptr advances, wrapping at NUM_LANES-1 to 0.
- ready_out = active & (!full[ptr] | group_load). group_load is the condition defined under group load below.
- Group load: at a boundary, if active and every holding register is full, then:
  - all holding registers move to the shift registers;
  - valid_out_lane goes to all 1 for the next DATA_W cycles;
  - full flags clear, except when the same cycle accepts a new word into holding[0], in which case full[0] stays set.
- Otherwise, at a boundary, every lane loads the idle word and valid_out_lane goes to 0. A partial group waits.
- Inactive link (any active_lane bit 0):
  - ready_out=0;
  - the word currently shifting completes;
  - subsequent boundaries load idle;
  - holding contents and ptr are retained;
  - transmission resumes on the first boundary after re-activation.
- Simultaneous accept and group load in the same cycle is legal, giving zero bubble at full throughput of NUM_LANES words per DATA_W cycles.
- Reset mid-word: the word is aborted and held words are discarded.

Optional Feature:
- Macro STRIPE_PARTIAL_FLUSH_EN.
- Defined: at a boundary with active, ptr!=0, the group incomplete and valid_in=0:
  - lanes 0..ptr-1 load their held words with valid_out_lane=1;
  - the remaining lanes load idle with valid_out_lane=0;
  - those flags clear and ptr resets to 0.
- Undefined: partial groups wait indefinitely.

Test Plan:
- NUM_LANES=2, DATA_W=32, all active, accept 0xDEADBEEF then 0x12345678 before boundary → after next boundary, lane0 serializes DEADBEEF MSB-first and lane1 serializes 12345678 in the same 32 cycles, with valid_out_lane=2'b11 and word_start at bit 0.
- No input after reset → from cycle 32 each lane repeats 0xBCBCBCBC, valid_out_lane=0, word_start every 32 cycles.
- Continuous valid_in stream of 8 words → ready_out drops only while both holding registers are full; no idle word between groups; output order is w0/w1, w2/w3, w4/w5, w6/w7.
- Clear active_lane[1] mid-word → current word finishes; ready_out=0; idle on following boundaries; held word retained and sent after active returns.
- Single word 0xA5A5A5A5 then valid_in=0 → without the macro, lanes stay idle indefinitely; with STRIPE_PARTIAL_FLUSH_EN, lane0 sends A5A5A5A5 and lane1 idles at the next boundary.
- reset_L pulsed low at bit 10 of a data word → all outputs go to 0 immediately; after release, first idle word appears 32 cycles later.
